// File: rtl/apu_request_buffer_if.sv
// rtl/apu_request_buffer_if.sv - APU request/grant/result channel; the master side issues requests, the slave side grants and returns results
interface apu_request_buffer_if;
  logic             req;
  logic             gnt;
  logic [2:0][31:0] operands;
  logic [5:0]       op;
  logic [14:0]      flags;
  logic             rvalid;
  logic [31:0]      result;
  logic [4:0]       rflags;

  modport master (
    output req, operands, op, flags,
    input  gnt, rvalid, result, rflags
  );

  modport slave (
    input  req, operands, op, flags,
    output gnt, rvalid, result, rflags
  );
endinterface

// File: rtl/apu_request_buffer.sv
// rtl/apu_request_buffer.sv - elastic APU request FIFO between the core and accelerator_top, with an issue limit and a registered result return
// Optional same-cycle bypass when the FIFO is empty: define APU_BUF_BYPASS_EN.
module apu_request_buffer #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                      clk,
  input  logic                      n_reset,
  apu_request_buffer_if.slave       core,
  apu_request_buffer_if.master      acc,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      core_entry;
  entry_t      head_entry;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [2:0]  outstanding;
  logic        empty;
  logic        full;
  logic        can_issue;
  logic        push;
  logic        pop;
  logic        issue;
  logic        ret_ok;
  logic        rvalid_q;
  logic [31:0] result_q;
  logic [4:0]  rflags_q;

  // Extra pointer MSB separates the full and empty cases when the index bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign can_issue  = (outstanding < 3'(MAX_OUT));
  assign core_entry = {core.operands, core.op, core.flags};
  assign head_entry = mem[rd_ptr[AW-1:0]];

`ifdef APU_BUF_BYPASS_EN
  logic bypass;
  assign bypass       = empty & can_issue;
  assign acc.req      = bypass ? core.req : (~empty & can_issue);
  assign acc.operands = bypass ? core.operands : head_entry.operands;
  assign acc.op       = bypass ? core.op : head_entry.op;
  assign acc.flags    = bypass ? core.flags : head_entry.flags;
  // A bypassed request the accelerator refuses is parked in the FIFO, so the core is always granted.
  assign core.gnt     = core.req & (bypass | ~full);
  assign issue        = acc.req & acc.gnt;
  assign pop          = issue & ~bypass;
  assign push         = core.req & ~full & ~(bypass & acc.gnt);
`else
  assign acc.req      = ~empty & can_issue;
  assign acc.operands = head_entry.operands;
  assign acc.op       = head_entry.op;
  assign acc.flags    = head_entry.flags;
  assign core.gnt     = core.req & ~full;
  assign issue        = acc.req & acc.gnt;
  assign pop          = issue;
  assign push         = core.req & ~full;
`endif

  assign ret_ok = acc.rvalid & (outstanding != 3'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= core_entry;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err_o       <= 1'b0;
      rvalid_q    <= 1'b0;
      result_q    <= '0;
      rflags_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (issue && !ret_ok)      outstanding <= outstanding + 3'd1;
      else if (!issue && ret_ok) outstanding <= outstanding - 3'd1;
      // An unsolicited result is flagged but still forwarded to the core.
      if (acc.rvalid && outstanding == 3'd0) err_o <= 1'b1;
      rvalid_q <= acc.rvalid;
      if (acc.rvalid) begin
        result_q <= acc.result;
        rflags_q <= acc.rflags;
      end
    end
  end

  assign core.rvalid = rvalid_q;
  assign core.result = result_q;
  assign core.rflags = rflags_q;
  assign occupancy_o = wr_ptr - rd_ptr;
  assign busy_o      = ~empty | (outstanding != 3'd0);
endmodule

// File: tb/tb_apu_request_buffer.sv
// tb/tb_apu_request_buffer.sv - directed vector table plus hand sequences for apu_request_buffer
module tb_apu_request_buffer;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [2:0] occupancy;
  logic       busy;
  logic       err;
  int         n_cmp = 0;
  int         n_bad = 0;

  apu_request_buffer_if core_if ();
  apu_request_buffer_if acc_if ();

  apu_request_buffer #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .core        (core_if),
    .acc         (acc_if),
    .occupancy_o (occupancy),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    logic        e_cgnt;
    logic        e_areq;
    logic [2:0]  e_occ;
    logic        e_busy;
    logic        e_err;
    logic        e_crv;
    logic [31:0] e_res;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic req, logic gnt, logic rv, logic [31:0] res,
                              logic cg, logic ar, logic [2:0] occ, logic b,
                              logic e, logic crv, logic [31:0] eres);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.res = res;
    v.e_cgnt = cg; v.e_areq = ar; v.e_occ = occ; v.e_busy = b;
    v.e_err = e; v.e_crv = crv; v.e_res = eres;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic req, logic [31:0] k, logic gnt, logic rv, logic [31:0] res);
    core_if.req      = req;
    core_if.operands = {32'hC000_0000 + k, 32'hB000_0000 + k, 32'hA000_0000 + k};
    core_if.op       = k[5:0];
    core_if.flags    = 15'(k * 3 + 1);
    acc_if.gnt       = gnt;
    acc_if.rvalid    = rv;
    acc_if.result    = res;
    acc_if.rflags    = res[4:0];
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,0,       0,0,0,0,0,0,0);
    tbl[1]  = mk(1,1,0,0,       1,0,0,0,0,0,0);
    tbl[2]  = mk(0,1,0,0,       0,1,1,1,0,0,0);
    tbl[3]  = mk(0,1,0,0,       0,0,0,1,0,0,0);
    tbl[4]  = mk(0,0,1,32'h10,  0,0,0,1,0,0,0);
    tbl[5]  = mk(0,0,0,0,       0,0,0,0,0,1,32'h10);
    tbl[6]  = mk(0,0,0,0,       0,0,0,0,0,0,32'h10);
    tbl[7]  = mk(1,0,0,0,       1,0,0,0,0,0,32'h10);
    tbl[8]  = mk(1,0,0,0,       1,1,1,1,0,0,32'h10);
    tbl[9]  = mk(1,0,0,0,       1,1,2,1,0,0,32'h10);
    tbl[10] = mk(1,0,0,0,       1,1,3,1,0,0,32'h10);
    tbl[11] = mk(1,0,0,0,       0,1,4,1,0,0,32'h10);
    tbl[12] = mk(1,1,0,0,       0,1,4,1,0,0,32'h10);
    tbl[13] = mk(0,1,0,0,       0,1,3,1,0,0,32'h10);
    tbl[14] = mk(0,1,0,0,       0,0,2,1,0,0,32'h10);
    tbl[15] = mk(0,0,1,32'h22,  0,0,2,1,0,0,32'h10);
    tbl[16] = mk(0,0,0,0,       0,1,2,1,0,1,32'h22);
    tbl[17] = mk(1,1,1,32'h33,  1,1,2,1,0,0,32'h22);
    tbl[18] = mk(0,0,0,0,       0,1,2,1,0,1,32'h33);
    tbl[19] = mk(0,1,0,0,       0,1,2,1,0,0,32'h33);
    tbl[20] = mk(0,1,1,32'h44,  0,0,1,1,0,0,32'h33);
    tbl[21] = mk(0,1,1,32'h55,  0,1,1,1,0,1,32'h44);
    tbl[22] = mk(0,0,1,32'h66,  0,0,0,1,0,1,32'h55);
    tbl[23] = mk(0,0,0,0,       0,0,0,0,0,1,32'h66);
    tbl[24] = mk(0,0,1,32'h77,  0,0,0,0,0,0,32'h66);
    tbl[25] = mk(0,0,0,0,       0,0,0,0,1,1,32'h77);
    tbl[26] = mk(0,0,0,0,       0,0,0,0,1,0,32'h77);

    do_reset();
    @(negedge clk);

`ifdef APU_BUF_BYPASS_EN
    drive(1'b1, 32'h5, 1'b1, 1'b0, 0);
    #1;
    chk("byp_acc_req", 128'(acc_if.req), 128'd1);
    chk("byp_core_gnt", 128'(core_if.gnt), 128'd1);
    chk("byp_op", 128'(acc_if.op), 128'd5);
    @(negedge clk);
    drive(1'b1, 32'h9, 1'b0, 1'b0, 0);
    #1;
    chk("byp_occ0", 128'(occupancy), 128'd0);
    chk("byp_ngnt_core_gnt", 128'(core_if.gnt), 128'd1);
    chk("byp_ngnt_acc_req", 128'(acc_if.req), 128'd1);
    @(negedge clk);
    drive(1'b0, 0, 1'b1, 1'b0, 0);
    #1;
    chk("byp_queued_occ", 128'(occupancy), 128'd1);
    chk("byp_queued_op", 128'(acc_if.op), 128'd9);
    @(negedge clk);
`else
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].req, 32'(i), tbl[i].gnt, tbl[i].rv, tbl[i].res);
      #1;
      chk($sformatf("v%0d_core_gnt", i), 128'(core_if.gnt), 128'(tbl[i].e_cgnt));
      chk($sformatf("v%0d_acc_req", i), 128'(acc_if.req), 128'(tbl[i].e_areq));
      chk($sformatf("v%0d_occupancy", i), 128'(occupancy), 128'(tbl[i].e_occ));
      chk($sformatf("v%0d_busy", i), 128'(busy), 128'(tbl[i].e_busy));
      chk($sformatf("v%0d_err", i), 128'(err), 128'(tbl[i].e_err));
      chk($sformatf("v%0d_core_rvalid", i), 128'(core_if.rvalid), 128'(tbl[i].e_crv));
      chk($sformatf("v%0d_core_result", i), 128'(core_if.result), 128'(tbl[i].e_res));
      @(negedge clk);
    end
`endif

    // Reset asserted mid-stream with queued entries.
    drive(1'b1, 32'h40, 1'b0, 1'b0, 0);
    @(negedge clk);
    drive(1'b1, 32'h41, 1'b0, 1'b0, 0);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    #1;
    chk("pre_rst_occupancy", 128'(occupancy), 128'd2);
    chk("pre_rst_busy", 128'(busy), 128'd1);
    n_reset = 1'b0;
    #1;
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_occupancy", 128'(occupancy), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_core_rvalid", 128'(core_if.rvalid), 128'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

`ifndef APU_BUF_BYPASS_EN
    begin
      logic [116:0] sb [$];
      logic [116:0] exp_p;
      int pushed = 0;
      int got = 0;
      logic rv_next = 1'b0;
      for (int cyc = 0; cyc < 200 && (got < 8 || rv_next); cyc++) begin
        drive(pushed < 8, 32'(pushed), (cyc % 3) != 1, rv_next, 32'(100 + got));
        #1;
        rv_next = 1'b0;
        if (acc_if.req) begin
          if (sb.size() == 0) begin
            chk("wrap_unexpected_req", 128'(acc_if.req), 128'd0);
          end else begin
            exp_p = sb[0];
            chk($sformatf("wrap_payload_%0d", got),
                128'({acc_if.operands, acc_if.op, acc_if.flags}), 128'(exp_p));
            if (acc_if.gnt) begin
              void'(sb.pop_front());
              got++;
              rv_next = 1'b1;
            end
          end
        end
        if (core_if.req && core_if.gnt) begin
          sb.push_back({core_if.operands, core_if.op, core_if.flags});
          pushed++;
        end
        @(negedge clk);
      end
      drive(1'b0, 0, 1'b0, 1'b0, 0);
      #1;
      chk("wrap_transfers", 128'(got), 128'd8);
      chk("wrap_busy_end", 128'(busy), 128'd0);
      chk("wrap_err_end", 128'(err), 128'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
